// File: rtl/cpu_output_trace_buffer_if.sv
// rtl/cpu_output_trace_buffer_if.sv - capture bus and read-side handshake of the CPU output trace buffer
interface cpu_output_trace_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] cpu_output;
   logic              capture_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output cpu_output, capture_en, rd_en,
      input  rd_data, rd_valid, empty, full, count, overflow
   );

   modport slave (
      input  cpu_output, capture_en, rd_en,
      output rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/cpu_output_trace_buffer.sv
// rtl/cpu_output_trace_buffer.sv - captures changed CPU result values into a drop-on-full FIFO
module cpu_output_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic clk,
   input  logic reset,
   cpu_output_trace_buffer_if.slave bus
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_next;
   logic [DATA_W-1:0] last_val;
   logic [DATA_W-1:0] rd_data_q;
   logic              primed;
   logic              empty_q;
   logic              full_q;
   logic              rd_valid_q;
   logic              overflow_q;
   logic              hit;
   logic              pop;
   logic              push_acc;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   always_comb begin
      hit        = bus.capture_en & (~primed | (bus.cpu_output != last_val));
      pop        = bus.rd_en & ~empty_q;
      push_acc   = hit & (~full_q | pop);
      count_next = count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         last_val   <= '0;
         primed     <= 1'b0;
      end else begin
         if (hit) begin
            last_val <= bus.cpu_output;
            primed   <= 1'b1;
         end
         if (push_acc) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (hit & full_q & ~pop) begin
            overflow_q <= 1'b1;
         end
         rd_valid_q <= pop;
         if (pop) begin
            rd_data_q <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + ADDR_W'(1);
         end
         count_q <= count_next;
         empty_q <= (count_next == '0);
         full_q  <= (count_next == (ADDR_W+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= bus.cpu_output;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_cpu_output_trace_buffer.sv
// tb/tb_cpu_output_trace_buffer.sv - directed and randomized checks of the trace buffer against a queue model
module tb_cpu_output_trace_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   cpu_output_trace_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cpu_output_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO contents as a queue plus the change-detect history.
   logic [DATA_W-1:0] m_fifo[$];
   logic [DATA_W-1:0] m_last;
   bit                m_primed;
   bit                m_ovf;
   logic [DATA_W-1:0] m_rd_data;
   bit                m_rd_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit hit;
      bit pop;
      if (reset) begin
         m_fifo.delete();
         m_last     = '0;
         m_primed   = 0;
         m_ovf      = 0;
         m_rd_data  = '0;
         m_rd_valid = 0;
      end else begin
         hit = bus.capture_en && (!m_primed || bus.cpu_output != m_last);
         pop = bus.rd_en && m_fifo.size() > 0;
         m_rd_valid = pop;
         if (pop) m_rd_data = m_fifo.pop_front();
         if (hit) begin
            m_last   = bus.cpu_output;
            m_primed = 1;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.cpu_output);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("count",    32'(bus.count), 32'(m_fifo.size()));
      check("empty",    32'(bus.empty), 32'(m_fifo.size() == 0));
      check("full",     32'(bus.full),  32'(m_fifo.size() == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      check("rd_data",  bus.rd_data, m_rd_data);
   endtask

   task automatic drive(input bit rst, input bit cap, input logic [DATA_W-1:0] val, input bit rd);
      reset          = rst;
      bus.capture_en = cap;
      bus.cpu_output = val;
      bus.rd_en      = rd;
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] t2_vals [7];
      logic [DATA_W-1:0] t2_exp  [4];
      t2_vals = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd5, 32'd7, 32'd0};
      t2_exp  = '{32'd0, 32'd5, 32'd7, 32'd0};
      bus.capture_en = 1'b0;
      bus.cpu_output = '0;
      bus.rd_en      = 1'b0;

      // T1 reset
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      check("t1_empty", 32'(bus.empty), 32'd1);
      check("t1_full", 32'(bus.full), 32'd0);
      check("t1_count", 32'(bus.count), 32'd0);
      check("t1_overflow", 32'(bus.overflow), 32'd0);
      check("t1_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("t1_rd_data", bus.rd_data, 32'd0);

      // T2 capture of changed values, first zero included
      for (int i = 0; i < 7; i++) drive(0, 1, t2_vals[i], 0);
      check("t2_count", 32'(bus.count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 1);
         check("t2_rd_valid", 32'(bus.rd_valid), 32'd1);
         check("t2_rd_data", bus.rd_data, t2_exp[i]);
      end
      drive(0, 1, 0, 1);
      check("t2_empty_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("t2_empty_rd_hold", bus.rd_data, 32'd0);

      // T3 gating
      for (int v = 1; v <= 3; v++) drive(0, 0, v, 0);
      check("t3_gated_count", 32'(bus.count), 32'd0);
      drive(0, 1, 3, 0);
      drive(0, 1, 3, 0);
      check("t3_count", 32'(bus.count), 32'd1);
      drive(0, 1, 3, 1);
      check("t3_data", bus.rd_data, 32'd3);

      // T4 overflow
      for (int v = 1; v <= 17; v++) drive(0, 1, v, 0);
      check("t4_full", 32'(bus.full), 32'd1);
      check("t4_count", 32'(bus.count), 32'd16);
      check("t4_overflow", 32'(bus.overflow), 32'd1);
      for (int v = 1; v <= 16; v++) begin
         drive(0, 1, 17, 1);
         check("t4_drain", bus.rd_data, 32'(v));
      end
      check("t4_overflow_sticky", 32'(bus.overflow), 32'd1);

      // T5 full with simultaneous push and pop
      for (int v = 100; v < 116; v++) drive(0, 1, v, 0);
      drive(0, 1, 200, 1);
      check("t5_count", 32'(bus.count), 32'd16);
      check("t5_popped_oldest", bus.rd_data, 32'd100);
      for (int i = 0; i < 16; i++) drive(0, 1, 200, 1);
      check("t5_new_last", bus.rd_data, 32'd200);

      // T6 wrap, then reset with entries pending
      drive(1, 0, 0, 0);
      for (int v = 0; v < 5; v++) drive(0, 1, 1000 + v, 0);
      for (int v = 5; v < 45; v++) drive(0, 1, 1000 + v, 1);
      check("t6_count", 32'(bus.count), 32'd5);
      check("t6_order", bus.rd_data, 32'd1039);
      drive(1, 0, 0, 0);
      check("t6_reset_count", 32'(bus.count), 32'd0);
      check("t6_reset_empty", 32'(bus.empty), 32'd1);
      drive(0, 1, 0, 0);
      check("t6_first_capture", 32'(bus.count), 32'd1);

      // Randomized traffic with small value set to provoke repeats
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 3) != 0),
               32'($urandom_range(0, 5)),
               ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
